// File: rtl/hwpe_ctrl_periph_initiator_pkg.sv
// Shared types for the periph initiator: command and response records plus reset constants.
// Response IDs are stored at a fixed maximum width so the type does not depend on ID_WIDTH.
package hwpe_ctrl_package;

    localparam int unsigned HWPE_CTRL_MAX_ID_WIDTH = 8;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } hwpe_ctrl_initiator_cmd_t;

    typedef struct packed {
        logic [31:0]                       data;
        logic [HWPE_CTRL_MAX_ID_WIDTH-1:0] id;
        logic                              err;
    } hwpe_ctrl_initiator_rsp_t;

    localparam int unsigned HWPE_CTRL_RSP_WIDTH = $bits(hwpe_ctrl_initiator_rsp_t);

    // Idle bus value: nothing addressed, write-enable deasserted (active-low).
    localparam hwpe_ctrl_initiator_cmd_t HWPE_CTRL_CMD_RESET = '{
        add:  32'h0,
        wen:  1'b1,
        be:   4'h0,
        data: 32'h0
    };

endpackage

// File: rtl/hwpe_ctrl_initiator_rsp_fifo.sv
// Registered response FIFO; output is the head entry, valid one cycle after the push.
// Push and pop may happen in the same cycle at any fill level, including full.
module hwpe_ctrl_initiator_rsp_fifo
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           push_i,
    input  logic [HWPE_CTRL_RSP_WIDTH-1:0] data_i,
    input  logic                           pop_i,
    output logic [HWPE_CTRL_RSP_WIDTH-1:0] data_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [HWPE_CTRL_RSP_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]               r_wr_ptr;
    logic [PTR_W-1:0]               r_rd_ptr;
    logic [CNT_W-1:0]               r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign full_o  = (r_count == DEPTH_C);
    assign empty_o = (r_count == '0);

    // Overflow means the upstream credit scheme is broken.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        !(push_i && full_o && !pop_i));

endmodule

// File: rtl/hwpe_ctrl_periph_initiator.sv
// Drives the periph req/gnt + r_valid protocol from a valid/ready command stream.
// A credit counter bounds accepted-but-unpopped transactions so responses are never lost.
module hwpe_ctrl_periph_initiator
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned ID_WIDTH        = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [31:0]         cmd_add_i,
    input  logic                cmd_wen_i,
    input  logic [3:0]          cmd_be_i,
    input  logic [31:0]         cmd_data_i,
    output logic                periph_req_o,
    input  logic                periph_gnt_i,
    output logic [31:0]         periph_add_o,
    output logic                periph_wen_o,
    output logic [3:0]          periph_be_o,
    output logic [31:0]         periph_data_o,
    output logic [ID_WIDTH-1:0] periph_id_o,
    input  logic [31:0]         periph_r_data_i,
    input  logic                periph_r_valid_i,
    input  logic [ID_WIDTH-1:0] periph_r_id_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_data_o,
    output logic [ID_WIDTH-1:0] rsp_id_o,
    output logic                rsp_err_o,
    output logic                err_o,
    output logic                idle_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic                     r_req;
    hwpe_ctrl_initiator_cmd_t r_cmd;
    logic [ID_WIDTH-1:0]      r_id;
    logic [ID_WIDTH-1:0]      r_exp;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         r_gp;
    logic                     r_err;

    logic                     w_accept;
    logic                     w_gnt;
    logic                     w_pop;
    logic                     w_rvalid_ok;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_id_overflow;
    hwpe_ctrl_initiator_rsp_t w_push_rsp;
    hwpe_ctrl_initiator_rsp_t w_pop_rsp;

    assign cmd_ready_o = (~r_req | periph_gnt_i) & (r_cnt < MAX_CNT);
    assign w_accept    = cmd_valid_i & cmd_ready_o;
    assign w_gnt       = r_req & periph_gnt_i;
    assign w_pop       = rsp_valid_o & rsp_ready_i;
    assign w_rvalid_ok = periph_r_valid_i & (r_gp != '0);

    // A new command may be loaded in the grant cycle, giving one transaction per cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_req <= 1'b0;
            r_cmd <= HWPE_CTRL_CMD_RESET;
            r_id  <= '0;
        end else begin
            if (w_accept) begin
                r_req      <= 1'b1;
                r_cmd.add  <= cmd_add_i;
                r_cmd.wen  <= cmd_wen_i;
                r_cmd.be   <= cmd_be_i;
                r_cmd.data <= cmd_data_i;
            end else if (w_gnt) begin
                r_req <= 1'b0;
            end
            if (w_gnt) begin
                r_id <= r_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_cnt <= '0;
            r_gp  <= '0;
            r_exp <= '0;
            r_err <= 1'b0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            case ({w_gnt, w_rvalid_ok})
                2'b10:   r_gp <= r_gp + 1'b1;
                2'b01:   r_gp <= r_gp - 1'b1;
                default: r_gp <= r_gp;
            endcase
            if (periph_r_valid_i) begin
                r_exp <= r_exp + 1'b1;
            end
            // A response with nothing granted is dropped but remembered.
            if (periph_r_valid_i && (r_gp == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_push_rsp.data = periph_r_data_i;
    assign w_push_rsp.id   = HWPE_CTRL_MAX_ID_WIDTH'(periph_r_id_i);
    assign w_push_rsp.err  = (periph_r_id_i != r_exp);

    hwpe_ctrl_initiator_rsp_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (w_rvalid_ok),
        .data_i  (w_push_rsp),
        .pop_i   (w_pop),
        .data_o  (w_pop_rsp),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Stored IDs wider than ID_WIDTH cannot occur; any such bits are reported as a bad ID.
    assign w_id_overflow = ((w_pop_rsp.id >> ID_WIDTH) != '0);

    assign periph_req_o  = r_req;
    assign periph_add_o  = r_cmd.add;
    assign periph_wen_o  = r_cmd.wen;
    assign periph_be_o   = r_cmd.be;
    assign periph_data_o = r_cmd.data;
    assign periph_id_o   = r_id;

    assign rsp_valid_o = ~w_fifo_empty;
    assign rsp_data_o  = w_pop_rsp.data;
    assign rsp_id_o    = w_pop_rsp.id[ID_WIDTH-1:0];
    assign rsp_err_o   = ~w_fifo_empty & (w_pop_rsp.err | w_id_overflow);
    assign err_o       = r_err;
    assign idle_o      = ~r_req & (r_cnt == '0) & w_fifo_empty;

    a_full_implies_credit_exhausted: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        w_fifo_full |-> (r_cnt == MAX_CNT));

endmodule

// File: tb/tb_hwpe_ctrl_periph_initiator.sv
// Bench for the periph initiator: directed scenarios plus a randomized phase, all checked
// every cycle against a queue-based transaction model of the initiator and an in-order slave.
module tb_hwpe_ctrl_periph_initiator;

    localparam int ID_W = 2;
    localparam int MAXO = 4;
    localparam int NIDS = 4;

    logic            clk;
    logic            rstN;
    logic            clear;
    logic            cmdValid;
    logic            cmd_ready_o;
    logic [31:0]     cmdAdd;
    logic            cmdWen;
    logic [3:0]      cmdBe;
    logic [31:0]     cmdData;
    logic            periph_req_o;
    logic            gnt;
    logic [31:0]     periph_add_o;
    logic            periph_wen_o;
    logic [3:0]      periph_be_o;
    logic [31:0]     periph_data_o;
    logic [ID_W-1:0] periph_id_o;
    logic [31:0]     rData;
    logic            rValid;
    logic [ID_W-1:0] rId;
    logic            rsp_valid_o;
    logic            rspReady;
    logic [31:0]     rsp_data_o;
    logic [ID_W-1:0] rsp_id_o;
    logic            rsp_err_o;
    logic            err_o;
    logic            idle_o;

    hwpe_ctrl_periph_initiator #(
        .ID_WIDTH        (ID_W),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rstN),
        .clear_i          (clear),
        .cmd_valid_i      (cmdValid),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_add_i        (cmdAdd),
        .cmd_wen_i        (cmdWen),
        .cmd_be_i         (cmdBe),
        .cmd_data_i       (cmdData),
        .periph_req_o     (periph_req_o),
        .periph_gnt_i     (gnt),
        .periph_add_o     (periph_add_o),
        .periph_wen_o     (periph_wen_o),
        .periph_be_o      (periph_be_o),
        .periph_data_o    (periph_data_o),
        .periph_id_o      (periph_id_o),
        .periph_r_data_i  (rData),
        .periph_r_valid_i (rValid),
        .periph_r_id_i    (rId),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rspReady),
        .rsp_data_o       (rsp_data_o),
        .rsp_id_o         (rsp_id_o),
        .rsp_err_o        (rsp_err_o),
        .err_o            (err_o),
        .idle_o           (idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    // Transaction-level model: one pending request, granted IDs awaiting a response,
    // and the list of responses the consumer has yet to take.
    typedef struct {
        logic [31:0] data;
        int          id;
        bit          err;
    } rspEntry_t;

    bit          modelValid = 0;
    bit          mPend;
    logic [31:0] mAdd;
    logic [31:0] mData;
    logic        mWen;
    logic [3:0]  mBe;
    int          mNextId;
    int          mExpId;
    int          mOut;
    bit          mErr;
    int          mAcceptCount = 0;
    int          grantedQ[$];
    rspEntry_t   rspQ[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: actual %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPend   = 0;
        mAdd    = 32'h0;
        mData   = 32'h0;
        mWen    = 1'b1;
        mBe     = 4'h0;
        mNextId = 0;
        mExpId  = 0;
        mOut    = 0;
        mErr    = 0;
        grantedQ.delete();
        rspQ.delete();
    endtask

    function automatic bit modelIdle();
        return !mPend && (mOut == 0) && (rspQ.size() == 0);
    endfunction

    // Called at the falling edge with inputs already driven; checks, then advances one clock.
    task automatic applyStimulus();
        bit expReady;
        bit acc;
        bit gntE;
        bit popE;
        rspEntry_t e;
        #1;
        expReady = (!mPend || gnt) && (mOut < MAXO);
        if (modelValid) begin
            checkOutput("req", periph_req_o, mPend);
            if (mPend) begin
                checkOutput("add", periph_add_o, mAdd);
                checkOutput("wen", periph_wen_o, mWen);
                checkOutput("be", periph_be_o, mBe);
                checkOutput("wdata", periph_data_o, mData);
            end
            checkOutput("id", periph_id_o, mNextId);
            checkOutput("cmdReady", cmd_ready_o, expReady);
            checkOutput("rspValid", rsp_valid_o, rspQ.size() != 0);
            if (rspQ.size() != 0) begin
                checkOutput("rspData", rsp_data_o, rspQ[0].data);
                checkOutput("rspId", rsp_id_o, rspQ[0].id);
                checkOutput("rspErr", rsp_err_o, rspQ[0].err);
            end
            checkOutput("errSticky", err_o, mErr);
            checkOutput("idle", idle_o, modelIdle());
        end
        acc  = cmdValid && expReady;
        gntE = mPend && gnt;
        popE = (rspQ.size() != 0) && rspReady;
        @(posedge clk);
        if (!rstN || clear) begin
            modelReset();
            modelValid = 1;
        end else if (modelValid) begin
            if (popE) begin
                void'(rspQ.pop_front());
                mOut--;
            end
            if (rValid) begin
                if (grantedQ.size() != 0) begin
                    e.data = rData;
                    e.id   = int'(rId);
                    e.err  = (int'(rId) != mExpId);
                    rspQ.push_back(e);
                    void'(grantedQ.pop_front());
                end else begin
                    mErr = 1;
                end
                mExpId = (mExpId + 1) % NIDS;
            end
            if (gntE) begin
                grantedQ.push_back(mNextId);
                mNextId = (mNextId + 1) % NIDS;
                mPend   = 0;
            end
            if (acc) begin
                mPend = 1;
                mAdd  = cmdAdd;
                mWen  = cmdWen;
                mBe   = cmdBe;
                mData = cmdData;
                mOut++;
                mAcceptCount++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idleInputs();
        cmdValid = 0;
        gnt      = 0;
        rValid   = 0;
        rId      = '0;
        rData    = 32'h0;
        rspReady = 0;
        clear    = 0;
    endtask

    task automatic doReset();
        idleInputs();
        rstN = 0;
        applyStimulus();
        applyStimulus();
        rstN = 1;
    endtask

    // In-order slave: answer the oldest granted ID when asked to.
    task automatic slaveRespond(input bit fire);
        rValid = fire && (grantedQ.size() != 0);
        rId    = rValid ? ID_W'(grantedQ[0]) : '0;
        rData  = $urandom;
    endtask

    initial begin
        int idSeen[$];
        int errSeen[$];
        int firstGnt;
        int lastGnt;
        int base;
        int dutAcc;
        int rspCount;
        int respIdx;

        cmdAdd  = 32'h0;
        cmdWen  = 1'b1;
        cmdBe   = 4'h0;
        cmdData = 32'h0;
        modelReset();
        idleInputs();
        rstN = 0;
        @(negedge clk);
        doReset();

        // Single write with grant two cycles late.
        cmdValid = 1; cmdAdd = 32'h20; cmdWen = 0; cmdBe = 4'hF; cmdData = 32'hCAFEF00D;
        applyStimulus();
        cmdValid = 0;
        for (int k = 0; k < 3; k++) begin
            gnt = (k == 2);
            checkOutput("t1ReqHeld", periph_req_o, 1);
            checkOutput("t1Add", periph_add_o, 32'h20);
            checkOutput("t1Wen", periph_wen_o, 0);
            checkOutput("t1Data", periph_data_o, 32'hCAFEF00D);
            checkOutput("t1Id", periph_id_o, 0);
            applyStimulus();
        end
        gnt = 0; rValid = 1; rId = 0; rData = 32'h5A5A0001;
        checkOutput("t1ReqDrop", periph_req_o, 0);
        checkOutput("t1NotIdle", idle_o, 0);
        applyStimulus();
        rValid = 0; rspReady = 1;
        checkOutput("t1RspValid", rsp_valid_o, 1);
        checkOutput("t1RspData", rsp_data_o, 32'h5A5A0001);
        checkOutput("t1RspErr", rsp_err_o, 0);
        applyStimulus();
        rspReady = 0;
        checkOutput("t1Idle", idle_o, 1);

        // Eight back-to-back reads with immediate grant and one-cycle responses.
        doReset();
        base = mAcceptCount; rspReady = 1; gnt = 1; cmdWen = 1; rspCount = 0;
        firstGnt = -1; lastGnt = -1;
        for (int c = 0; c < 14; c++) begin
            cmdValid = (mAcceptCount - base) < 8;
            cmdAdd   = $urandom;
            cmdBe    = 4'(c);
            slaveRespond(1);
            if (periph_req_o === 1'b1) begin
                idSeen.push_back(int'(periph_id_o));
                if (firstGnt < 0) firstGnt = c;
                lastGnt = c;
            end
            if (rsp_valid_o === 1'b1) rspCount++;
            applyStimulus();
        end
        idleInputs();
        checkOutput("t2NumReq", idSeen.size(), 8);
        checkOutput("t2ReqSpan", lastGnt - firstGnt, 7);
        checkOutput("t2NumRsp", rspCount, 8);
        for (int i = 0; i < idSeen.size(); i++) begin
            checkOutput("t2IdWrap", idSeen[i], i % 4);
        end

        // Credit limit with the consumer stalled.
        doReset();
        cmdValid = 1; gnt = 1; dutAcc = 0;
        for (int c = 0; c < 12; c++) begin
            slaveRespond(1);
            #1;
            if (cmd_ready_o === 1'b1) dutAcc++;
            applyStimulus();
        end
        checkOutput("t3Accepts", dutAcc, 4);
        checkOutput("t3ReadyLow", cmd_ready_o, 0);
        checkOutput("t3RspValid", rsp_valid_o, 1);
        dutAcc = 0; rValid = 0;
        for (int c = 0; c < 7; c++) begin
            rspReady = (c == 0);
            slaveRespond(1);
            #1;
            if (cmd_ready_o === 1'b1) dutAcc++;
            applyStimulus();
        end
        checkOutput("t3OneMore", dutAcc, 1);

        // Out-of-order ID on the second response only.
        doReset();
        rspReady = 1; gnt = 1; base = mAcceptCount; respIdx = 0;
        for (int c = 0; c < 9; c++) begin
            cmdValid = (mAcceptCount - base) < 3;
            slaveRespond(1);
            if (rValid) begin
                if (respIdx == 1) rId = 2;
                respIdx++;
            end
            if (rsp_valid_o === 1'b1) errSeen.push_back(int'(rsp_err_o));
            applyStimulus();
        end
        idleInputs();
        checkOutput("t4NumRsp", errSeen.size(), 3);
        if (errSeen.size() == 3) begin
            checkOutput("t4Err0", errSeen[0], 0);
            checkOutput("t4Err1", errSeen[1], 1);
            checkOutput("t4Err2", errSeen[2], 0);
        end
        checkOutput("t4NoSticky", err_o, 0);

        // Stray response while idle.
        doReset();
        rValid = 1; rId = 0; rData = 32'h1111;
        applyStimulus();
        rValid = 0;
        checkOutput("t5ErrSet", err_o, 1);
        checkOutput("t5NoRsp", rsp_valid_o, 0);
        for (int c = 0; c < 3; c++) applyStimulus();
        checkOutput("t5ErrSticky", err_o, 1);

        // Reset in the middle of traffic, then a late response.
        doReset();
        cmdValid = 1; cmdAdd = 32'hABCD0000; cmdData = 32'h55AA55AA; cmdBe = 4'h3; cmdWen = 0;
        applyStimulus();
        gnt = 1;
        applyStimulus();
        cmdValid = 0; gnt = 0;
        applyStimulus();
        checkOutput("t6ReqBefore", periph_req_o, 1);
        rstN = 0;
        applyStimulus();
        rstN = 1;
        checkOutput("t6Req", periph_req_o, 0);
        checkOutput("t6Add", periph_add_o, 0);
        checkOutput("t6Data", periph_data_o, 0);
        checkOutput("t6Be", periph_be_o, 0);
        checkOutput("t6Id", periph_id_o, 0);
        checkOutput("t6Wen", periph_wen_o, 1);
        checkOutput("t6Ready", cmd_ready_o, 1);
        checkOutput("t6RspValid", rsp_valid_o, 0);
        checkOutput("t6RspErr", rsp_err_o, 0);
        checkOutput("t6Err", err_o, 0);
        checkOutput("t6Idle", idle_o, 1);
        rValid = 1; rId = 1;
        applyStimulus();
        rValid = 0;
        checkOutput("t6LateErr", err_o, 1);

        // Randomized traffic.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            cmdValid = ($urandom_range(0, 2) != 0);
            cmdAdd   = $urandom;
            cmdWen   = 1'($urandom);
            cmdBe    = 4'($urandom);
            cmdData  = $urandom;
            gnt      = 1'($urandom);
            rspReady = ($urandom_range(0, 3) != 0);
            clear    = 0;
            slaveRespond($urandom_range(0, 1) == 1);
            if (rValid && $urandom_range(0, 7) == 0) rId = ID_W'($urandom);
            if (!rValid && grantedQ.size() == 0 && $urandom_range(0, 199) == 0) begin
                rValid = 1;
                rId    = ID_W'($urandom);
            end
            if (modelIdle() && !rValid && $urandom_range(0, 99) == 0) begin
                clear    = 1;
                cmdValid = 0;
            end
            applyStimulus();
        end
        idleInputs();
        applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
